// File: rtl/beta_shared_wr_buffer_if.sv
// Bus bundle for beta_shared_wr_buffer: Beta store/read side plus the projector-side
// stream.
interface beta_shared_wr_buffer_if #(
  parameter int DEPTH = 16,
  parameter int OFF_W = 14
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Beta side
  logic              sel_write_shared;
  logic              beta_mwr;
  logic              beta_moe;
  logic [15:0]       beta_addr;
  logic [31:0]       beta_wdata;
  logic [31:0]       beta_rdata;
  logic              beta_stall;

  // Stream handshake: the head {out_off, out_data} transfers on a rising clock edge
  // only when out_valid & out_ready are both high. While out_valid is high, the head
  // stays stable until that transfer. out_ready may be driven without regard to
  // out_valid.
  logic              out_valid;
  logic              out_ready;
  logic [OFF_W-1:0]  out_off;
  logic [31:0]       out_data;

  // Status
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  modport slave (
    input  sel_write_shared, beta_mwr, beta_moe, beta_addr, beta_wdata, out_ready,
    output beta_rdata, beta_stall, out_valid, out_off, out_data, fifo_count, overflow
  );

  modport master (
    output sel_write_shared, beta_mwr, beta_moe, beta_addr, beta_wdata, out_ready,
    input  beta_rdata, beta_stall, out_valid, out_off, out_data, fifo_count, overflow
  );
endinterface

// File: rtl/beta_shared_wr_buffer.sv
// Queues Beta stores to the shared write region in a fall-through FIFO and drains them to
// the projector. By default, a store to a full FIFO stalls the Beta. SHWR_DROP_ON_FULL_EN
// makes such a store drop instead and sets a sticky overflow flag.
module beta_shared_wr_buffer #(
  parameter int DEPTH = 16,
  parameter int OFF_W = 14
) (
  input  logic clk,
  input  logic rst_n,
  beta_shared_wr_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OFF_W + 32;

  logic [EW-1:0] storage [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_req;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          overflow_q;
  logic [8:0]    count_ext;

  assign push_req = bus.sel_write_shared & bus.beta_mwr;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = push_req & ~full;
  assign pop      = ~empty & bus.out_ready;

  // Storage is not reset. The head is read directly, so it falls through.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= {bus.beta_addr[OFF_W+1:2], bus.beta_wdata};
    end
  end

  // Pointer width equals log2(DEPTH), so the increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SHWR_DROP_ON_FULL_EN
  logic status_rd;
  logic unused_moe;

  assign status_rd  = bus.sel_write_shared & bus.beta_moe & ~bus.beta_mwr;
  assign unused_moe = 1'b0;

  // A drop and a status read on the same edge leave the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (push_req & full) begin
      overflow_q <= 1'b1;
    end else if (status_rd) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.beta_stall = 1'b0;
`else
  logic unused_moe;

  assign unused_moe     = bus.beta_moe;
  assign overflow_q     = 1'b0;
  assign bus.beta_stall = push_req & full;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.beta_addr[1:0];

  assign count_ext      = 9'(count);
  assign bus.out_valid  = ~empty;
  assign bus.out_off    = storage[rd_ptr][EW-1:32];
  assign bus.out_data   = storage[rd_ptr][31:0];
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.beta_rdata = {16'h0, overflow_q, 6'h0, count_ext};
endmodule

// File: tb/tb_beta_shared_wr_buffer.sv
// Self-checking bench for beta_shared_wr_buffer. A queue-based reference model predicts
// every output, and directed scenarios pin exact values.
module tb_beta_shared_wr_buffer;
  localparam int DEPTH = 16;
  localparam int OFF_W = 14;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  beta_shared_wr_buffer_if #(.DEPTH(DEPTH), .OFF_W(OFF_W)) bus ();

  beta_shared_wr_buffer #(.DEPTH(DEPTH), .OFF_W(OFF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [OFF_W+31:0] exp_q[$];
  logic              exp_ovf  = 1'b0;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    return {16'h0, exp_ovf, 6'h0, 9'(exp_q.size())};
  endfunction

  // Reference model: a plain queue of {offset, data}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      bit push_req;
      bit full;
      bit pop;
      bit status_rd;
      push_req  = bus.sel_write_shared && bus.beta_mwr;
      full      = (exp_q.size() == DEPTH);
      pop       = (exp_q.size() != 0) && bus.out_ready;
      status_rd = bus.sel_write_shared && bus.beta_moe && !bus.beta_mwr;
      if (pop) void'(exp_q.pop_front());
      if (push_req && !full) exp_q.push_back({bus.beta_addr[15:2], bus.beta_wdata});
`ifdef SHWR_DROP_ON_FULL_EN
      if (status_rd) exp_ovf = 1'b0;
      if (push_req && full) exp_ovf = 1'b1;
`else
      if (status_rd) exp_ovf = 1'b0;
`endif
    end
  end

  // Compare process: every falling edge
  always @(negedge clk) begin
    chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    chk("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
    if (exp_q.size() != 0) chk("head", 64'({bus.out_off, bus.out_data}), 64'(exp_q[0]));
`ifdef SHWR_DROP_ON_FULL_EN
    chk("beta_stall", 64'(bus.beta_stall), 64'(0));
`else
    chk("beta_stall", 64'(bus.beta_stall),
        64'(bus.sel_write_shared && bus.beta_mwr && exp_q.size() == DEPTH));
`endif
    chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
    if (bus.sel_write_shared && bus.beta_moe) chk("beta_rdata", 64'(bus.beta_rdata), 64'(exp_rdata()));
  end

  // Driver tasks
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sel_write_shared = 1'b0;
    bus.beta_mwr         = 1'b0;
    bus.beta_moe         = 1'b0;
    bus.out_ready        = 1'b0;
  endtask

  task automatic store(input logic [15:0] addr, input logic [31:0] data);
    bus.sel_write_shared = 1'b1;
    bus.beta_mwr         = 1'b1;
    bus.beta_moe         = 1'b0;
    bus.beta_addr        = addr;
    bus.beta_wdata       = data;
  endtask

  task automatic status_read();
    bus.sel_write_shared = 1'b1;
    bus.beta_mwr         = 1'b0;
    bus.beta_moe         = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      store(16'(i * 4), 32'hA000_0000 + 32'(i));
      next_cycle();
    end
  endtask

  initial begin
    int ready_pct;
    idle();
    bus.beta_addr  = '0;
    bus.beta_wdata = '0;
    do_reset();

    // Reset state
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_count", 64'(bus.fifo_count), 64'd0);
    chk("reset_stall", 64'(bus.beta_stall), 64'd0);

    // Single store falls through on the next cycle
    store(16'h0010, 32'hDEADBEEF);
    next_cycle();
    idle();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_off", 64'(bus.out_off), 64'h0004);
    chk("single_data", 64'(bus.out_data), 64'hDEADBEEF);
    chk("single_count", 64'(bus.fifo_count), 64'd1);

    // Fill to full, stall, one pop, stalled store accepted
    do_reset();
    fill(DEPTH);
    chk("fill_count", 64'(bus.fifo_count), 64'd16);
    store(16'(16 * 4), 32'hA000_0010);
    #1;
    chk("full_stall", 64'(bus.beta_stall), 64'd1);
    chk("full_head_off", 64'(bus.out_off), 64'd0);
    bus.out_ready = 1'b1;
    next_cycle();
    chk("pop_count", 64'(bus.fifo_count), 64'd15);
    chk("pop_head_off", 64'(bus.out_off), 64'd1);
    bus.out_ready = 1'b0;
    next_cycle();
    chk("refill_count", 64'(bus.fifo_count), 64'd16);
    idle();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) next_cycle();
    chk("drain_count", 64'(bus.fifo_count), 64'd0);

    // Status read with five queued entries
    do_reset();
    fill(5);
    idle();
    status_read();
    #1;
    chk("status_5", 64'(bus.beta_rdata), 64'h0000_0005);
    next_cycle();
    idle();

    // Streaming: continuous stores, always ready, pointers wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      store(16'(i * 4), $urandom);
      next_cycle();
      chk("stream_count_le1", 64'(bus.fifo_count <= CW'(1)), 64'd1);
    end
    idle();
    bus.out_ready = 1'b1;
    repeat (3) next_cycle();
    chk("stream_drained", 64'(bus.fifo_count), 64'd0);

`ifdef SHWR_DROP_ON_FULL_EN
    // Drop on full sets overflow, status read clears it
    do_reset();
    fill(DEPTH);
    store(16'h0040, 32'h12345678);
    #1;
    chk("drop_stall", 64'(bus.beta_stall), 64'd0);
    next_cycle();
    idle();
    status_read();
    #1;
    chk("drop_rdata", 64'(bus.beta_rdata), 64'h0000_8010);
    next_cycle();
    chk("cleared_rdata", 64'(bus.beta_rdata), 64'h0000_0010);
    idle();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) next_cycle();
`endif

    // Asynchronous reset mid-stream
    do_reset();
    fill(7);
    idle();
    #1;
    chk("pre_rst_count", 64'(bus.fifo_count), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_count", 64'(bus.fifo_count), 64'd0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    next_cycle();
    store(16'h0154, 32'hCAFE_F00D);
    next_cycle();
    idle();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("post_rst_off", 64'(bus.out_off), 64'h0055);
    chk("post_rst_data", 64'(bus.out_data), 64'hCAFE_F00D);
    chk("post_rst_count", 64'(bus.fifo_count), 64'd1);

    // Randomized traffic with varying back-pressure; Beta holds while stalled
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      ready_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 250; c++) begin
        if (!bus.beta_stall) begin
          bus.sel_write_shared = ($urandom_range(0, 3) != 0);
          bus.beta_mwr         = $urandom_range(0, 1) == 1;
          bus.beta_moe         = !bus.beta_mwr && ($urandom_range(0, 3) == 0);
          bus.beta_addr        = 16'($urandom);
          bus.beta_wdata       = $urandom;
        end
        bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        next_cycle();
      end
    end
    idle();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 4) next_cycle();
    chk("final_empty", 64'(bus.fifo_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/beta_shared_wr_buffer.md
Name: beta_shared_wr_buffer

Overview:
- Downstream consumer of the Beta address decoder's shared-write select.
- Captures Beta stores into the shared write region (addr[30:16]==3) and queues them as {word offset, data} in a first-word-fall-through FIFO.
- Drains the FIFO to the laser projector logic over a valid/ready handshake, so projector-side back-pressure never corrupts CPU stores.
- Also returns a status word on Beta reads of the same region.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- OFF_W, 14, width of captured word offset (beta_addr[15:2]).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- sel_write_shared  in  1  decoder select for shared write region.
- beta_mwr  in  1  Beta memory write strobe.
- beta_moe  in  1  Beta memory output enable (read).
- beta_addr  in  16  Beta address bits [15:0]; bits [1:0] ignored.
- beta_wdata  in  32  Beta store data.
- beta_rdata  out  32  status word; meaningful when sel_write_shared & beta_moe.
- beta_stall  out  1  combinational; holds the Beta on a store to a full FIFO.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_off  out  OFF_W  head word offset.
- out_data  out  32  head data.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky dropped-store flag.

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=wr_ptr=0, count=0, overflow=0. Outputs follow: out_valid=0, fifo_count=0, beta_stall=0. out_off/out_data are don't-care but driven from storage (no X required).
- Storage contents are not reset.
- push_req = sel_write_shared & beta_mwr.
- full = (count==DEPTH); empty = (count==0); both derived from registered count.
- push = push_req & ~full. On push, storage[wr_ptr] <= {beta_addr[15:2], beta_wdata} and wr_ptr increments, wrapping modulo DEPTH.
- pop = out_valid & out_ready. On pop, rd_ptr increments, wrapping modulo DEPTH.
- out_valid = ~empty. out_off/out_data = storage[rd_ptr] (fall-through). A push into an empty FIFO gives out_valid=1 the next cycle, with the pushed entry on the outputs.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both or neither: unchanged.
- Push and pop in the same cycle while full: the pop is taken and the push is rejected (full is registered). The store retries next cycle via stall.
- Push and pop in the same cycle while empty: impossible, since out_valid=0.
- beta_stall = push_req & full (default build). Beta holds address/data/mwr until the stall drops; the store is accepted on the first cycle with count<DEPTH.
- Ordering: strict FIFO. No coalescing of stores to the same offset.
- beta_rdata = {16'h0, overflow, 6'h0, count zero-extended to 9 bits}. Pure combinational from registered state.
- Status-read side effect: on a clock edge with sel_write_shared & beta_moe & ~beta_mwr, overflow clears to 0. If a drop occurs in the same cycle, set wins.
- Asserting sel_write_shared without mwr/moe has no effect.
- Reset mid-operation discards all queued entries. out_valid drops asynchronously with rst_n.

Optional Feature:
- Macro SHWR_DROP_ON_FULL_EN.
- Defined:
  - beta_stall is tied to 0.
  - A push_req while full is discarded, and overflow is set to 1 on that edge.
  - The FIFO contents and pointers are unchanged by the drop.
- Undefined:
  - Stall behaviour as above.
  - overflow register is removed; overflow output and rdata[15] are tied to 0.

Test Plan:
- Reset then single store, addr=0x0003_0010, wdata=0xDEADBEEF, out_ready=0 -> next cycle out_valid=1, out_off=0x0004, out_data=0xDEADBEEF, fifo_count=1.
- 16 back-to-back stores with offsets 0..15, out_ready=0 -> fifo_count=16; a 17th store sees beta_stall=1. Raise out_ready for one cycle -> first pop returns offset 0, the stalled store is accepted the following cycle, fifo_count=16.
- Streaming with out_ready=1 and continuous stores for 40 cycles -> count stays at most 1, data emerges in order, pointers wrap past 15 with no loss.
- Status read (sel_write_shared=1, moe=1) with 5 entries queued -> beta_rdata=0x0000_0005.
- SHWR_DROP_ON_FULL_EN build: fill to 16, issue one more store 0x12345678 -> beta_stall=0, store absent from the drained sequence, beta_rdata=0x0000_8010. Next status read clears overflow -> 0x0000_0010.
- Assert rst_n=0 mid-stream with 7 entries queued -> out_valid=0 and fifo_count=0 immediately, before the next clock edge. After release, a new store appears as the sole head entry.
